uart_flow_ctrl: RTL and testbench

UART_FLOW_CTRL -- requirements
Module: uart_flow_ctrl

---
 rtl/apb_uart_pkg.sv | 30 +++
 rtl/bit_sync.sv | 35 +++
 rtl/uart_flow_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_flow_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_pkg.sv
// ============================================================================
// Module   : apb_uart_pkg
// Purpose  : Shared types for the UART block: flow-control FSM states and the
//            flow-control configuration register layout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_uart_pkg;

    localparam int RX_FIFO_SIZE  = 8;
    localparam int CFG_CNT_WIDTH = RX_FIFO_SIZE + 1;
    localparam int CFG_TO_WIDTH  = 16;

    typedef enum logic [1:0] {
        FLOW_IDLE     = 2'd0,
        FLOW_WAIT_CTS = 2'd1,
        FLOW_SEND     = 2'd2
    } flow_state_e;

    typedef struct packed {
        logic                     FLOW_EN;
        logic [CFG_CNT_WIDTH-1:0] RTS_HI_THR;
        logic [CFG_CNT_WIDTH-1:0] RTS_LO_THR;
        logic [CFG_TO_WIDTH-1:0]  CTS_TO_LIM;
    } flow_cfg_reg_t;

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// ============================================================================
// Module   : bit_sync
// Purpose  : Multi-flop synchronizer for a single asynchronous input bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic d_i,
    output logic q_o
);

    // Fewer than two flops gives no metastability protection.
    localparam int c_STAGES = (STAGES < 2) ? 2 : STAGES;

    logic [c_STAGES-1:0] r_sync;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_sync <= {c_STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[c_STAGES-2:0], d_i};
        end
    end

    assign q_o = r_sync[c_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_flow_ctrl.sv
// ============================================================================
// Module   : uart_flow_ctrl
// Purpose  : RTS/CTS hardware flow control between the TX FIFO and uart_tx,
//            with CTS wait timeout and RX-occupancy driven RTS hysteresis.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_flow_ctrl
    import apb_uart_pkg::*;
#(
    parameter int CNT_WIDTH   = RX_FIFO_SIZE + 1,
    parameter int TO_WIDTH    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 flow_en_i,
    input  logic [CNT_WIDTH-1:0] rts_hi_thr_i,
    input  logic [CNT_WIDTH-1:0] rts_lo_thr_i,
    input  logic [TO_WIDTH-1:0]  cts_to_lim_i,
    input  logic [CNT_WIDTH-1:0] rx_count_i,
    input  logic                 cts_ni,
    output logic                 rts_no,
    input  logic [7:0]           s_data_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic [7:0]           m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 cts_to_o
);

    flow_state_e         r_state;
    logic [7:0]          r_hold;
    logic [TO_WIDTH-1:0] r_to_cnt;
    logic                r_s_ready;
    logic                r_m_valid;
    logic                r_cts_to;
    logic                r_rts_n;

    logic                w_cts_sync;
    logic                w_cts_ok;
    logic [TO_WIDTH-1:0] w_cnt_inc;

    // CTS idles deasserted (high) so nothing is sent until the peer asserts it.
    bit_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cts_sync (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .d_i     (cts_ni),
        .q_o     (w_cts_sync)
    );

    assign w_cts_ok  = ~flow_en_i | ~w_cts_sync;
    assign w_cnt_inc = r_to_cnt + TO_WIDTH'(1);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state   <= FLOW_IDLE;
            r_hold    <= '0;
            r_to_cnt  <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_cts_to  <= 1'b0;
        end else begin
            r_cts_to <= 1'b0;
            case (r_state)
                FLOW_IDLE: begin
                    r_s_ready <= 1'b1;
                    if (s_valid_i && r_s_ready) begin
                        r_hold    <= s_data_i;
                        r_s_ready <= 1'b0;
                        r_to_cnt  <= '0;
                        if (w_cts_ok) begin
                            r_state   <= FLOW_SEND;
                            r_m_valid <= 1'b1;
                        end else begin
                            r_state   <= FLOW_WAIT_CTS;
                        end
                    end
                end
                FLOW_WAIT_CTS: begin
                    if (w_cts_ok) begin
                        r_state   <= FLOW_SEND;
                        r_m_valid <= 1'b1;
                        r_to_cnt  <= '0;
                    end else if ((cts_to_lim_i != '0) && (w_cnt_inc == cts_to_lim_i)) begin
                        // Byte stays held; software decides whether to give up.
                        r_cts_to <= 1'b1;
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= w_cnt_inc;
                    end
                end
                FLOW_SEND: begin
                    if (m_ready_i) begin
                        r_state   <= FLOW_IDLE;
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= FLOW_IDLE;
                    r_m_valid <= 1'b0;
                    r_s_ready <= 1'b0;
                end
            endcase
        end
    end

    // High threshold wins so a misprogrammed hi<=lo pair still stops the peer.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rts_n <= 1'b1;
        end else if (!flow_en_i) begin
            r_rts_n <= 1'b0;
        end else if (rx_count_i >= rts_hi_thr_i) begin
            r_rts_n <= 1'b1;
        end else if (rx_count_i <= rts_lo_thr_i) begin
            r_rts_n <= 1'b0;
        end
    end

    assign rts_no    = r_rts_n;
    assign s_ready_o = r_s_ready;
    assign m_valid_o = r_m_valid;
    assign m_data_o  = r_hold;
    assign cts_to_o  = r_cts_to;

endmodule

`default_nettype wire

// File: tb/tb_uart_flow_ctrl.sv
// ============================================================================
// Module   : tb_uart_flow_ctrl
// Purpose  : Scoreboard bench for uart_flow_ctrl: directed scenarios plus a
//            randomized phase against a behavioural reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_flow_ctrl;

    localparam int CW = 9;
    localparam int TW = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          arst_ni = 1'b0;
    logic          flow_en = 1'b0;
    logic          cts_ni = 1'b1;
    logic [CW-1:0] hi = 9'd200;
    logic [CW-1:0] lo = 9'd100;
    logic [CW-1:0] rx = '0;
    logic [TW-1:0] lim = '0;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          rts_no, s_ready, m_valid, cts_to;
    logic [7:0]    m_data;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_flow_ctrl #(
        .CNT_WIDTH   (CW),
        .TO_WIDTH    (TW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_i        (clk),
        .arst_ni      (arst_ni),
        .flow_en_i    (flow_en),
        .rts_hi_thr_i (hi),
        .rts_lo_thr_i (lo),
        .cts_to_lim_i (lim),
        .rx_count_i   (rx),
        .cts_ni       (cts_ni),
        .rts_no       (rts_no),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .cts_to_o     (cts_to)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RTS rule as a decision: 0 = request peer to send, 1 = stop peer, 2 = keep.
    function automatic int rts_decision(input logic en, input int cnt, input int h, input int l);
        if (!en)      return 0;
        if (cnt >= h) return 1;
        if (cnt <= l) return 0;
        return 2;
    endfunction

    logic exp_rts;
    always @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            exp_rts <= 1'b1;
        end else begin
            case (rts_decision(flow_en, int'(rx), int'(hi), int'(lo)))
                0:       exp_rts <= 1'b0;
                1:       exp_rts <= 1'b1;
                default: exp_rts <= exp_rts;
            endcase
        end
    end

    // Monitor: scoreboard of accepted bytes, hold-while-stalled rule, RTS reference.
    logic       pend = 1'b0;
    logic [7:0] pend_data = '0;
    always @(negedge clk) begin
        if (!arst_ni) begin
            exp_q.delete();
            pend = 1'b0;
        end else begin
            check("rts_ref", 32'(rts_no), 32'(exp_rts));
            if (pend) begin
                check("m_valid_hold", 32'(m_valid), 32'd1);
                check("m_data_hold", 32'(m_data), 32'(pend_data));
            end
            if (s_valid && s_ready) exp_q.push_back(s_data);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got byte 0x%0h, expected no byte", m_data);
                end else begin
                    check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
            end
            pend      = m_valid && !m_ready;
            pend_data = m_data;
        end
    end

    task automatic push(input logic [7:0] d);
        int acc;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = d;
        acc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready) begin
                acc = 1;
                break;
            end
        end
        check("accept", 32'(acc), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_valid) begin
                seen = 1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int prev_v;
        int prev_rising;
        logic exp_r;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rts", 32'(rts_no), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_cts_to", 32'(cts_to), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        arst_ni = 1'b1;
        repeat (2) @(negedge clk);
        check("s_ready_after_rst", 32'(s_ready), 32'd1);

        // Flow control off: one-cycle latency, RTS asserted
        @(posedge clk); #1;
        flow_en = 1'b0; cts_ni = 1'b1; m_ready = 1'b1;
        push(8'hA5);
        @(negedge clk);
        check("nofc_m_valid", 32'(m_valid), 32'd1);
        check("nofc_m_data", 32'(m_data), 32'hA5);
        check("nofc_rts", 32'(rts_no), 32'd0);

        // Flow control on, CTS deasserted: wait, then SYNC_STAGES+1 after CTS
        @(posedge clk); #1;
        flow_en = 1'b1; hi = 9'd200; lo = 9'd100; rx = '0; cts_ni = 1'b1;
        push(8'h3C);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wait_m_valid", 32'(m_valid), 32'd0);
            check("wait_s_ready", 32'(s_ready), 32'd0);
        end
        @(posedge clk); #1;
        cts_ni = 1'b0;
        for (int k = 0; k <= SS + 1; k++) begin
            @(negedge clk);
            check("cts_latency", 32'(m_valid), (k == SS + 1) ? 32'd1 : 32'd0);
        end
        check("cts_m_data", 32'(m_data), 32'h3C);

        // CTS timeout pulses every 10 cycles after entry
        @(posedge clk); #1;
        cts_ni = 1'b1; lim = 16'd10;
        repeat (4) @(posedge clk);
        push(8'h96);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            check("cts_to_pulse", 32'(cts_to),
                  ((c - 1) > 0 && ((c - 1) % 10) == 0) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        cts_ni = 1'b0;
        wait_valid("to_delivered", 10);

        // Timeout disabled: no pulses
        @(posedge clk); #1;
        cts_ni = 1'b1; lim = '0;
        repeat (4) @(posedge clk);
        push(8'h11);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cts_to) pulses++;
        end
        check("lim0_no_pulse", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        cts_ni = 1'b0;
        wait_valid("lim0_delivered", 10);

        // RTS hysteresis sweep 0 -> 250 -> 0
        @(posedge clk); #1;
        flow_en = 1'b1; hi = 9'd200; lo = 9'd100; rx = '0;
        repeat (2) @(posedge clk);
        prev_v = -1;
        prev_rising = 1;
        for (int s = 0; s <= 500; s++) begin
            @(posedge clk); #1;
            rx = (s <= 250) ? CW'(s) : CW'(500 - s);
            @(negedge clk);
            if (prev_v >= 0) begin
                exp_r = prev_rising ? (prev_v >= 200) : (prev_v > 100);
                check("rts_sweep", 32'(rts_no), 32'(exp_r));
            end
            prev_v = int'(rx);
            prev_rising = (s < 250) ? 1 : 0;
        end

        // Misconfigured thresholds: high condition wins
        @(posedge clk); #1;
        hi = 9'd50; lo = 9'd80; rx = 9'd60;
        @(posedge clk);
        @(negedge clk);
        check("misconf_hi", 32'(rts_no), 32'd1);
        @(posedge clk); #1;
        rx = 9'd30;
        @(posedge clk);
        @(negedge clk);
        check("misconf_lo", 32'(rts_no), 32'd0);

        // SEND holds through CTS deassert and flow_en drop
        @(posedge clk); #1;
        hi = 9'd200; lo = 9'd100; rx = '0; flow_en = 1'b1; cts_ni = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        push(8'h5A);
        @(posedge clk); #1;
        cts_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("send_hold_valid", 32'(m_valid), 32'd1);
            check("send_hold_data", 32'(m_data), 32'h5A);
            if (i == 3) flow_en = 1'b0;
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;

        // Reset mid-SEND discards the byte
        push(8'h77);
        @(negedge clk);
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        @(posedge clk); #1;
        arst_ni = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_m_data", 32'(m_data), 32'd0);
        check("mid_rst_rts", 32'(rts_no), 32'd1);
        check("mid_rst_cts_to", 32'(cts_to), 32'd0);
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        arst_ni = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(m_valid), 32'd0);
        end
        check("post_rst_s_ready", 32'(s_ready), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 15) == 0) flow_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) cts_ni = ~cts_ni;
            m_ready = 1'($urandom_range(0, 1));
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            rx      = CW'($urandom_range(0, 300));
            if ($urandom_range(0, 31) == 0) begin
                hi = CW'($urandom_range(0, 300));
                lo = CW'($urandom_range(0, 300));
            end
            lim = TW'($urandom_range(0, 7));
        end
        @(posedge clk); #1;
        s_valid = 1'b0; flow_en = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) break;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
